// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the multi-cycle radix-2 divide sequencer.
package div_seq_pkg;

   localparam int unsigned REG_W    = 32;
   localparam int unsigned DREG_W   = 64;
   localparam logic [5:0]  DIV_ITER = 6'd32;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_seq.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle, result held until start drops.
module div_seq
   import div_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              signed_div_i,
   input  logic [REG_W-1:0]  opdata1_i,
   input  logic [REG_W-1:0]  opdata2_i,
   input  logic              start_i,
   input  logic              annul_i,
   output logic [DREG_W-1:0] result_o,
   output logic              ready_o
);

   div_state_e        state_q, state_d;
   logic [64:0]       dividend_q, dividend_d;
   logic [REG_W-1:0]  divisor_q, divisor_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              neg_quot_q, neg_quot_d;
   logic              neg_rem_q, neg_rem_d;
   logic [DREG_W-1:0] result_q, result_d;
   logic              ready_q, ready_d;

   logic [REG_W:0]    diff;
   logic [REG_W-1:0]  quot_fix;
   logic [REG_W-1:0]  rem_fix;

   assign diff     = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
   // Sign corrections use flags captured at start, so late operand changes cannot leak in.
   assign quot_fix = neg_if(dividend_q[31:0], neg_quot_q);
   assign rem_fix  = neg_if(dividend_q[64:33], neg_rem_q);

   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      cnt_d      = cnt_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;

      unique case (state_q)
         DIV_FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = DIV_BYZERO;
               end else begin
                  state_d    = DIV_ON;
                  dividend_d = {32'b0, neg_if(opdata1_i, signed_div_i && opdata1_i[REG_W-1]), 1'b0};
                  divisor_d  = neg_if(opdata2_i, signed_div_i && opdata2_i[REG_W-1]);
                  cnt_d      = '0;
                  neg_quot_d = signed_div_i && (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                  neg_rem_d  = signed_div_i && opdata1_i[REG_W-1];
               end
            end
         end

         DIV_BYZERO: begin
            dividend_d = '0;
            result_d   = '0;
            ready_d    = 1'b1;
            state_d    = DIV_END;
         end

         DIV_ON: begin
            if (annul_i) begin
               state_d  = DIV_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q < DIV_ITER) begin
               if (diff[REG_W]) begin
                  dividend_d = {dividend_q[63:0], 1'b0};
               end else begin
                  dividend_d = {diff[REG_W-1:0], dividend_q[31:0], 1'b1};
               end
               cnt_d = cnt_q + 6'd1;
            end else begin
               result_d = {rem_fix, quot_fix};
               ready_d  = 1'b1;
               state_d  = DIV_END;
            end
         end

         DIV_END: begin
            if (!start_i) begin
               state_d  = DIV_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end

         default: state_d = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DIV_FREE;
         dividend_q <= '0;
         divisor_q  <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         cnt_q      <= cnt_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit divide sequencer serving the EX stage for DIV/DIVU. EX raises `start_i` with operands and holds it; the block runs a restoring radix-2 division, one quotient bit per cycle. It then presents `{remainder, quotient}` for EX to forward as `{hi_o, lo_o}` with `whilo_o`. While the division runs, EX holds its pipeline stall request high. The result ends up in the HI/LO register.

## Interface

Parameters: none. Widths come from `RegBus` (32) and `DoubleRegBus` (64).

- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset (`RstEnable`).
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  EX request; level, held until EX sees `ready_o`.
- `annul_i`  in  1  abort: flush or exception squashing the DIV in EX.
- `result_o`  out  64  `{remainder[63:32], quotient[31:0]}`.
- `ready_o`  out  1  result valid (`DivResultReady`).

## Operation

States: FREE, BYZERO, ON, END.

Datapath registers:
- `dividend`: 65-bit working register, `{partial_rem, quot}`.
- `divisor`: 32-bit register.
- `cnt`: 6-bit counter.

FREE:
- `start_i`=1 and `annul_i`=0 and `opdata2_i`=0 → BYZERO.
- `start_i`=1 and `annul_i`=0 and `opdata2_i`≠0 → ON, with this load:
  - Take |operand| when `signed_div_i`=1, otherwise the raw value.
  - `dividend` = `{32'b0, abs_op1, 1'b0}`.
  - `divisor` = abs_op2.
  - `cnt` = 0.
- Otherwise stay in FREE.

BYZERO:
- Load `dividend` = 0 and go to END.
- The result is quotient 0, remainder 0. No trap.

ON, when `annul_i`=1:
- Go to FREE.
- Leave `result_o` = 0 and `ready_o` = 0.

ON, when `annul_i`=0 and `cnt` < 32 (one iteration per cycle):
- diff = `dividend[63:32]` − `divisor`, computed 33 bits wide.
- diff negative → `dividend` = `dividend << 1`.
- diff non-negative → `dividend` = `{diff[31:0], dividend[31:0], 1'b1}`.
- `cnt`++.

ON, when `cnt`=32 (sign fix, then go to END):
- Quotient = `dividend[31:0]`. Negate it when `signed_div_i` and the operand signs differ.
- Remainder = `dividend[64:33]`. Negate it when `signed_div_i` and `opdata1_i[31]`=1.

END:
- `result_o` = fixed `{rem, quot}`; `ready_o` = 1.
- `start_i`=0 → FREE, with `ready_o` = 0 and `result_o` = 0.
- `start_i`=1 → stay in END. The result holds, whatever `annul_i` is.

Operand sampling:
- Operands and `signed_div_i` are sampled only on the FREE→ON/BYZERO edge.
- Later changes on those inputs are ignored.
- The sign-fix step uses sign bits registered at start.

Arithmetic rules:
- |x| is two's-complement negation, taken modulo 2^32.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.

Reset:
- `rst`=1 at any edge, in any state: state = FREE, `cnt` = 0, `dividend` = 0, `result_o` = 0, `ready_o` = 0.
- Reset applied mid-ON abandons the operation.

## Timing

Cycle numbering: cycle 0 is the first cycle `start_i`=1 is seen in FREE; cycle n follows the n-th rising edge after it.

Normal divide:
- Cycle 1: ON, `cnt`=0.
- Cycles 2..33: `cnt` = 1..32.
- Cycle 34: END, `ready_o` = 1.
- Latency is 34 cycles, independent of the operands.

Divide by zero:
- Cycle 1: BYZERO.
- Cycle 2: END, `ready_o` = 1.

Back-to-back:
- EX drops `start_i` in the first cycle it sees `ready_o`; the block returns to FREE one edge later.
- A new `start_i` is accepted in the cycle after that.
- Minimum gap between results is 36 cycles.

`annul_i` during ON:
- Seen in cycle k; the block is FREE in cycle k+1.
- `ready_o` is never asserted for that operation.

`annul_i` in FREE together with `start_i`: no start.

Outputs are registered; no combinational path from inputs to `result_o`/`ready_o`.

## Structure

Constants in `defines.v`:
- `DivFree` = 2'b00, `DivByZero` = 2'b01, `DivOn` = 2'b10, `DivEnd` = 2'b11.
- `DivResultReady`/`DivResultNotReady`.
- `DivStart`/`DivStop`.
- `DoubleRegBus` = 63:0.

Single module; no sub-module. EX (separate change) adds DIV/DIVU ops, drives `start_i`, and routes `result_o` to `{hi_o, lo_o}`. EX raises stall while `start_i`=1 and `ready_o`=0.

## Test plan

- DIVU 100/7 → `ready_o` rises in cycle 34; `result_o` = `{0x00000002, 0x0000000E}`; after `start_i` drops, `ready_o` = 0 and `result_o` = 0.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → `{0xFFFFFFFF, 0xFFFFFFFD}`. DIV 7/−2 → `{0x00000001, 0xFFFFFFFD}`.
- DIV 0x80000000/0xFFFFFFFF → `{0x00000000, 0x80000000}`. DIVU 0xFFFFFFFF/1 → `{0, 0xFFFFFFFF}`.
- Divisor 0 → `ready_o` in cycle 2, `result_o` = 0. Operands changed during ON (5/2 → 9/3) → result still `{1, 2}`.
- `annul_i` pulsed at cycle 10 → FREE in cycle 11, no `ready_o`. A new start immediately after produces a correct result.
- `rst` asserted at cycle 20 of ON → state FREE, outputs 0 after that edge. `start_i` held through END for 5 cycles → result stable throughout.
